// File: rtl/melody_seq.sv
// melody_seq: programmable multi-step note sequencer.
//
// Holds a writable table of DEPTH steps, each {half-period, duration}.
// Playback walks the table from step 0, producing a square wave on `tone`
// for each step (half-period 0 = rest), and either stops or wraps at the end.
//
// Ports:
//   clk_in   system clock
//   rst      synchronous active-high reset (table contents are kept)
//   wr_en    table write strobe; wr_addr/wr_div/wr_dur give the entry
//   start    start or restart playback at step 0
//   stop     abort playback (wins over start)
//   loop     wrap to step 0 at the end of the sequence instead of stopping
//   tone     square-wave output
//   playing  high while playing
//   step     index of the current step
//   done     one-cycle pulse at the end of a non-looping sequence
module melody_seq #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 24,
    parameter int DUR_W = 8,
    parameter int TICK  = 12_000
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DIV_W-1:0]         wr_div,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     tone,
    output logic                     playing,
    output logic [$clog2(DEPTH)-1:0] step,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Note table; read asynchronously, so a same-edge write is seen only
    // after the edge (a load on that edge picks up the old contents).
    logic [DIV_W-1:0] div_mem_r [DEPTH];
    logic [DUR_W-1:0] dur_mem_r [DEPTH];

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] cur_div_r;
    logic [DUR_W-1:0] cur_dur_r;
    logic [DIV_W-1:0] tone_cnt_r;
    logic [TW-1:0]    tick_cnt_r;
    logic [DUR_W-1:0] dur_cnt_r;
    logic [AW-1:0]    step_r;
    logic             tone_r;
    logic             playing_r;
    logic             done_r;

    logic             load_s;
    logic [AW-1:0]    load_addr_s;
    logic             done_s;
    logic [AW-1:0]    next_addr_s;
    logic             entry0_empty_s;
    logic             step_end_s;
    logic             seq_end_s;

    assign tone    = tone_r;
    assign playing = playing_r;
    assign step    = step_r;
    assign done    = done_r;

    // Table write port; no reset so contents survive rst.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            div_mem_r[wr_addr] <= wr_div;
            dur_mem_r[wr_addr] <= wr_dur;
        end
    end

    // Step-end and sequence-end detection.
    always_comb begin
        next_addr_s    = step_r + AW'(1);
        entry0_empty_s = (dur_mem_r[0] == '0);
        step_end_s     = (tick_cnt_r == TICK_LAST) &&
                         (dur_cnt_r == (cur_dur_r - DUR_W'(1)));
        // next_addr_s wraps to 0 on the last step, but that case is already
        // caught by the STEP_LAST term.
        seq_end_s      = (step_r == STEP_LAST) || (dur_mem_r[next_addr_s] == '0);
    end

    // Next-state logic: decides when to load a step and when to pulse done.
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        load_addr_s = '0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (entry0_empty_s) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_PLAY;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    // Restart; an empty entry 0 ends playback like a
                    // non-looping end.
                    if (entry0_empty_s) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else if (step_end_s) begin
                    if (!seq_end_s) begin
                        load_s      = 1'b1;
                        load_addr_s = next_addr_s;
                    end else if (loop && !entry0_empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, step registers, tone and duration counters.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cur_div_r  <= '0;
            cur_dur_r  <= '0;
            tone_cnt_r <= '0;
            tick_cnt_r <= '0;
            dur_cnt_r  <= '0;
            step_r     <= '0;
            tone_r     <= 1'b0;
            playing_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= done_s;
            if (load_s) begin
                cur_div_r  <= div_mem_r[load_addr_s];
                cur_dur_r  <= dur_mem_r[load_addr_s];
                step_r     <= load_addr_s;
                tone_cnt_r <= '0;
                tick_cnt_r <= '0;
                dur_cnt_r  <= '0;
                tone_r     <= 1'b0;
                playing_r  <= 1'b1;
            end else if (state_s == ST_IDLE) begin
                cur_div_r  <= '0;
                cur_dur_r  <= '0;
                tone_cnt_r <= '0;
                tick_cnt_r <= '0;
                dur_cnt_r  <= '0;
                step_r     <= '0;
                tone_r     <= 1'b0;
                playing_r  <= 1'b0;
            end else begin
                // Square wave: toggle every cur_div clocks; rest holds 0.
                if (cur_div_r == '0) begin
                    tone_cnt_r <= '0;
                    tone_r     <= 1'b0;
                end else if (tone_cnt_r == (cur_div_r - DIV_W'(1))) begin
                    tone_cnt_r <= '0;
                    tone_r     <= ~tone_r;
                end else begin
                    tone_cnt_r <= tone_cnt_r + DIV_W'(1);
                end
                // Duration: count ticks of TICK clocks each.
                if (tick_cnt_r == TICK_LAST) begin
                    tick_cnt_r <= '0;
                    dur_cnt_r  <= dur_cnt_r + DUR_W'(1);
                end else begin
                    tick_cnt_r <= tick_cnt_r + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/melody_seq.md
# melody_seq

Programmable multi-step note sequencer, the parametrised successor of the fixed three-note sequencer. It holds a writable table of DEPTH steps; each step stores a tone half-period (0 = rest) and a duration. Playback generates a square-wave `tone` for each step in turn, with single-shot or loop modes. It sits between the board clock and the buzzer pin and is loaded by a host or ROM-init FSM through a simple write port.

## Interface
- `DEPTH`, 8: number of steps in the table; power of two, at least 2.
- `DIV_W`, 24: width of the half-period field, in clocks.
- `DUR_W`, 8: width of the duration field, in ticks.
- `TICK`, 12_000: clocks per duration tick (1 ms at 12 MHz); at least 1.
- `clk_in`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  log2(DEPTH)  table write address.
- `wr_div`  in  DIV_W  half-period; 0 = rest.
- `wr_dur`  in  DUR_W  duration in ticks; 0 = end-of-sequence marker.
- `start`  in  1  start, or restart, at step 0.
- `stop`  in  1  abort playback.
- `loop`  in  1  when 1, wrap to step 0 at end instead of stopping; sampled at end of sequence.
- `tone`  out  1  square-wave output.
- `playing`  out  1  high in PLAY.
- `step`  out  log2(DEPTH)  index of the current step.
- `done`  out  1  one-cycle pulse at end of a non-looping sequence.

## Operation
- Table: DEPTH entries of {div, dur}, with asynchronous read. A write happens on the clock edge when `wr_en`=1, in any state. Contents are not cleared by `rst`.
- States: IDLE and PLAY.
- IDLE → PLAY on `start`=1 and `stop`=0: load entry 0.
  - If entry 0 has dur=0, stay in IDLE and pulse `done`.
- PLAY → IDLE on `stop`=1. `stop` beats `start` when both are asserted.
- In PLAY, `start`=1 reloads entry 0 (restart).
- Step load, in the same cycle as the transition: `cur_div`, `cur_dur` ← table[addr]; `step`←addr; tone counter←0; `tone`←0; tick and duration counters←0.
- If a write hits the address being loaded in the same cycle, the old contents are loaded (read-before-write).
- Tone: when `cur_div`≠0, the counter increments each clock. When counter == `cur_div`−1, the counter clears and `tone` toggles. Period = 2·`cur_div` clocks. When `cur_div`=0, `tone` is held at 0.
- Duration: the tick counter runs 0..TICK−1. The duration counter increments on each tick wrap. The step ends on the cycle where tick == TICK−1 and dur count == `cur_dur`−1. A step therefore lasts exactly `cur_dur`·TICK clocks.
- End of step: next = `step`+1.
  - If `step` == DEPTH−1, or table[next].dur == 0, the sequence has ended.
  - On end with `loop`=1: load entry 0. If entry 0 has dur=0, treat it as the non-looping end.
  - On end with `loop`=0: go to IDLE with `done`=1 for one cycle.
  - Otherwise load entry next.
- Entering IDLE by any path: `tone`←0, `step`←0, `playing`←0.
- Widths: all counters wrap-free by construction. Tone counter is DIV_W bits, duration counter DUR_W bits, tick counter is ceil(log2(TICK)) bits (min 1).

## Timing
- Reset values: `tone`=0, `playing`=0, `step`=0, `done`=0; state IDLE; all counters 0.
- `start` sampled at edge k: at k+1, `playing`=1, `step`=0, `tone`=0. First toggle of `tone` at edge k+`cur_div`.
- Step changes: `step` updates on the edge that ends the previous step. No idle gap between steps.
- `done` rises on the same edge as `playing` falls, and is high for exactly one cycle.
- `stop` at edge k: at k+1, `playing`=0 and `tone`=0. No `done` pulse.
- `rst` during PLAY: the next cycle is in the reset state. Table contents are kept.

## Test plan
Parameters for all scenarios: DEPTH=4, TICK=4, DIV_W=8, DUR_W=8.

- Table {(3,2),(5,1),(0,1),(2,0)}, `loop`=0, `start` pulse:
  - steps 0/1/2 last 8/4/4 clocks;
  - `tone` has period 6, then 10, then is held 0 (rest);
  - `done` pulses 16 clocks after `playing` rises.
- Same table, `loop`=1: step sequence 0,1,2,0,1,… with no gap; `done` never asserts; `stop` drops `playing` and `tone` on the next cycle.
- All 4 entries have dur=1, `loop`=0: ends after step 3 (DEPTH boundary); `done` pulses at clock 16.
- Entry 0 has dur=0, `start` pulse: `playing` stays 0; `done` pulses at k+1.
- Mid-playback:
  - `start` during step 2 restarts at step 0 with `tone`=0;
  - `start`+`stop` in the same cycle goes to IDLE;
  - `rst` mid-step gives all outputs 0 on the next cycle, and a replay matches the pre-reset table.
- Write to entry 1 while step 0 plays: the new values are used for step 1. A write to entry 1 on the exact load cycle of step 1 uses the old values.
